// File: rtl/axi_ddr3_arbiter.sv
// Two-master to one-slave AXI arbiter for a DDR3 controller port.
// One transaction is in flight at a time; every channel is combinationally muxed to the owner.
module axi_ddr3_arbiter #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_ID_WIDTH    = 4,
    parameter int AXI_BURST_WIDTH = 6,
    parameter int AXI_DATA_WIDTH  = 128
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    // master 0
    input  logic [AXI_ADDR_WIDTH-1:0]   m0_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     m0_awid,
    input  logic [AXI_BURST_WIDTH-1:0]  m0_awlen,
    input  logic                        m0_awvalid,
    output logic                        m0_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   m0_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                        m0_wvalid,
    output logic                        m0_wready,
    output logic                        m0_wlast,
    output logic [AXI_ID_WIDTH-1:0]     m0_bid,
    output logic [1:0]                  m0_bresp,
    output logic                        m0_bvalid,
    input  logic                        m0_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m0_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     m0_arid,
    input  logic [AXI_BURST_WIDTH-1:0]  m0_arlen,
    input  logic                        m0_arvalid,
    output logic                        m0_arready,
    output logic [AXI_ID_WIDTH-1:0]     m0_rid,
    output logic [AXI_DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]                  m0_rresp,
    output logic                        m0_rvalid,
    output logic                        m0_rlast,
    input  logic                        m0_rready,
    // master 1
    input  logic [AXI_ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [AXI_ID_WIDTH-1:0]     m1_awid,
    input  logic [AXI_BURST_WIDTH-1:0]  m1_awlen,
    input  logic                        m1_awvalid,
    output logic                        m1_awready,
    input  logic [AXI_DATA_WIDTH-1:0]   m1_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                        m1_wvalid,
    output logic                        m1_wready,
    output logic                        m1_wlast,
    output logic [AXI_ID_WIDTH-1:0]     m1_bid,
    output logic [1:0]                  m1_bresp,
    output logic                        m1_bvalid,
    input  logic                        m1_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   m1_araddr,
    input  logic [AXI_ID_WIDTH-1:0]     m1_arid,
    input  logic [AXI_BURST_WIDTH-1:0]  m1_arlen,
    input  logic                        m1_arvalid,
    output logic                        m1_arready,
    output logic [AXI_ID_WIDTH-1:0]     m1_rid,
    output logic [AXI_DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]                  m1_rresp,
    output logic                        m1_rvalid,
    output logic                        m1_rlast,
    input  logic                        m1_rready,
    // slave
    output logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    output logic [AXI_ID_WIDTH-1:0]     s_awid,
    output logic [AXI_BURST_WIDTH-1:0]  s_awlen,
    output logic                        s_awvalid,
    input  logic                        s_awready,
    output logic [AXI_DATA_WIDTH-1:0]   s_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] s_wstrb,
    output logic                        s_wvalid,
    input  logic                        s_wready,
    input  logic                        s_wlast,
    input  logic [AXI_ID_WIDTH-1:0]     s_bid,
    input  logic [1:0]                  s_bresp,
    input  logic                        s_bvalid,
    output logic                        s_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    output logic [AXI_ID_WIDTH-1:0]     s_arid,
    output logic [AXI_BURST_WIDTH-1:0]  s_arlen,
    output logic                        s_arvalid,
    input  logic                        s_arready,
    input  logic [AXI_ID_WIDTH-1:0]     s_rid,
    input  logic [AXI_DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]                  s_rresp,
    input  logic                        s_rvalid,
    input  logic                        s_rlast,
    output logic                        s_rready,
    output logic [1:0]                  grant
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR  = 3'd1;
    localparam logic [2:0] WDATA = 3'd2;
    localparam logic [2:0] WRESP = 3'd3;
    localparam logic [2:0] RDATA = 3'd4;

    logic [2:0] state;
    logic       owner;     // 0 = m0, 1 = m1
    logic       is_write;
    logic       last_owner;

    logic req0, req1, pick;
    assign req0 = m0_awvalid | m0_arvalid;
    assign req1 = m1_awvalid | m1_arvalid;
    // On a tie the master not served last wins; a lone requester always wins.
    assign pick = (req0 & req1) ? ~last_owner : req1;

    logic aw_phase, ar_phase, w_phase, b_phase, r_phase;
    assign aw_phase = (state == ADDR) & is_write;
    assign ar_phase = (state == ADDR) & ~is_write;
    assign w_phase  = (state == WDATA);
    assign b_phase  = (state == WRESP);
    assign r_phase  = (state == RDATA);

    // Master-to-slave direction: owner's fields, zeroed outside their phase.
    assign s_awvalid = aw_phase & (owner ? m1_awvalid : m0_awvalid);
    assign s_awaddr  = aw_phase ? (owner ? m1_awaddr : m0_awaddr) : '0;
    assign s_awid    = aw_phase ? (owner ? m1_awid   : m0_awid)   : '0;
    assign s_awlen   = aw_phase ? (owner ? m1_awlen  : m0_awlen)  : '0;
    assign s_arvalid = ar_phase & (owner ? m1_arvalid : m0_arvalid);
    assign s_araddr  = ar_phase ? (owner ? m1_araddr : m0_araddr) : '0;
    assign s_arid    = ar_phase ? (owner ? m1_arid   : m0_arid)   : '0;
    assign s_arlen   = ar_phase ? (owner ? m1_arlen  : m0_arlen)  : '0;
    assign s_wvalid  = w_phase & (owner ? m1_wvalid : m0_wvalid);
    assign s_wdata   = w_phase ? (owner ? m1_wdata : m0_wdata) : '0;
    assign s_wstrb   = w_phase ? (owner ? m1_wstrb : m0_wstrb) : '0;
    assign s_bready  = b_phase & (owner ? m1_bready : m0_bready);
    assign s_rready  = r_phase & (owner ? m1_rready : m0_rready);

    // Slave-to-master direction: only the owner sees anything non-zero.
    logic sel0, sel1;
    assign sel0 = ~owner;
    assign sel1 = owner;

    assign m0_awready = aw_phase & sel0 & s_awready;
    assign m0_arready = ar_phase & sel0 & s_arready;
    assign m0_wready  = w_phase & sel0 & s_wready;
    assign m0_wlast   = w_phase & sel0 & s_wlast;
    assign m0_bvalid  = b_phase & sel0 & s_bvalid;
    assign m0_bid     = (b_phase & sel0) ? s_bid   : '0;
    assign m0_bresp   = (b_phase & sel0) ? s_bresp : '0;
    assign m0_rvalid  = r_phase & sel0 & s_rvalid;
    assign m0_rlast   = r_phase & sel0 & s_rlast;
    assign m0_rid     = (r_phase & sel0) ? s_rid   : '0;
    assign m0_rdata   = (r_phase & sel0) ? s_rdata : '0;
    assign m0_rresp   = (r_phase & sel0) ? s_rresp : '0;

    assign m1_awready = aw_phase & sel1 & s_awready;
    assign m1_arready = ar_phase & sel1 & s_arready;
    assign m1_wready  = w_phase & sel1 & s_wready;
    assign m1_wlast   = w_phase & sel1 & s_wlast;
    assign m1_bvalid  = b_phase & sel1 & s_bvalid;
    assign m1_bid     = (b_phase & sel1) ? s_bid   : '0;
    assign m1_bresp   = (b_phase & sel1) ? s_bresp : '0;
    assign m1_rvalid  = r_phase & sel1 & s_rvalid;
    assign m1_rlast   = r_phase & sel1 & s_rlast;
    assign m1_rid     = (r_phase & sel1) ? s_rid   : '0;
    assign m1_rdata   = (r_phase & sel1) ? s_rdata : '0;
    assign m1_rresp   = (r_phase & sel1) ? s_rresp : '0;

    // NOTE: state uses non-blocking assignments and a synchronous reset; last_owner resets to m1 so m0 wins the first tie.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= IDLE;
            owner      <= 1'b0;
            is_write   <= 1'b0;
            last_owner <= 1'b1;
            grant      <= 2'b00;
        end else begin
            case (state)
                IDLE: if (req0 | req1) begin
                    owner    <= pick;
                    is_write <= pick ? m1_awvalid : m0_awvalid;
                    grant    <= pick ? 2'b10 : 2'b01;
                    state    <= ADDR;
                end
                ADDR: begin
                    if (s_awvalid & s_awready)      state <= WDATA;
                    else if (s_arvalid & s_arready) state <= RDATA;
                end
                WDATA: if (s_wlast) state <= WRESP;
                WRESP: if (s_bvalid & s_bready) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    grant      <= 2'b00;
                end
                RDATA: if (s_rlast) begin
                    state      <= IDLE;
                    last_owner <= owner;
                    grant      <= 2'b00;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ddr3_arbiter.sv
// Directed self-checking bench for axi_ddr3_arbiter: reset, tie, single write,
// write priority, round-robin, slave stall and reset mid-burst.
module tb_axi_ddr3_arbiter;
    localparam int AW = 32, IW = 4, BW = 6, DW = 128, SW = DW / 8;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic [AW-1:0] m_awaddr [2], m_araddr [2];
    logic [IW-1:0] m_awid [2], m_arid [2], m_bid [2], m_rid [2];
    logic [BW-1:0] m_awlen [2], m_arlen [2];
    logic [DW-1:0] m_wdata [2], m_rdata [2];
    logic [SW-1:0] m_wstrb [2];
    logic [1:0]    m_bresp [2], m_rresp [2];
    logic [1:0]    m_awvalid, m_arvalid, m_wvalid, m_bready, m_rready;
    logic [1:0]    m_awready, m_arready, m_wready, m_wlast, m_bvalid, m_rvalid, m_rlast;

    logic [AW-1:0] s_awaddr, s_araddr;
    logic [IW-1:0] s_awid, s_arid, s_bid, s_rid;
    logic [BW-1:0] s_awlen, s_arlen;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [SW-1:0] s_wstrb;
    logic [1:0]    s_bresp, s_rresp, grant;
    logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
    logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;

    axi_ddr3_arbiter dut (
        .aclk(aclk), .aresetn(aresetn),
        .m0_awaddr(m_awaddr[0]), .m0_awid(m_awid[0]), .m0_awlen(m_awlen[0]),
        .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]),
        .m0_wready(m_wready[0]), .m0_wlast(m_wlast[0]),
        .m0_bid(m_bid[0]), .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m0_araddr(m_araddr[0]), .m0_arid(m_arid[0]), .m0_arlen(m_arlen[0]),
        .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rid(m_rid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rlast(m_rlast[0]), .m0_rready(m_rready[0]),
        .m1_awaddr(m_awaddr[1]), .m1_awid(m_awid[1]), .m1_awlen(m_awlen[1]),
        .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]),
        .m1_wready(m_wready[1]), .m1_wlast(m_wlast[1]),
        .m1_bid(m_bid[1]), .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .m1_araddr(m_araddr[1]), .m1_arid(m_arid[1]), .m1_arlen(m_arlen[1]),
        .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rid(m_rid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rlast(m_rlast[1]), .m1_rready(m_rready[1]),
        .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_wlast(s_wlast), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_araddr(s_araddr), .s_arid(s_arid),
        .s_arlen(s_arlen), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rlast(s_rlast),
        .s_rready(s_rready), .grant(grant)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive and sample 1 ns after the rising edge, away from it.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // One complete transaction for master m, starting from the IDLE cycle with requests already driven.
    task automatic txn(input int m, input bit wr, input int beats, input int bdelay,
                       input bit drop, input int stall_at, input int stall_len);
        int o;
        logic [1:0] g;
        logic [127:0] pat;
        o = 1 - m;
        g = (m == 1) ? 2'b10 : 2'b01;
        step();
        check("grant_addr", grant, g);
        if (wr) begin
            check("s_awvalid", s_awvalid, 1'b1);
            check("s_awaddr", s_awaddr, m_awaddr[m]);
            check("s_awid", s_awid, m_awid[m]);
            check("s_awlen", s_awlen, m_awlen[m]);
            check("s_arvalid_in_wr", s_arvalid, 1'b0);
            s_awready = 1'b1;
            #1;
            check("awready_own", m_awready[m], 1'b1);
            check("awready_other", m_awready[o], 1'b0);
            check("arready_own_in_wr", m_arready[m], 1'b0);
            step();
            s_awready = 1'b0;
            if (drop) m_awvalid[m] = 1'b0;
            for (int i = 0; i < beats; i++) begin
                pat = 128'((m + 1) * 256 + i);
                m_wvalid[m] = 1'b1;
                m_wdata[m]  = pat;
                m_wstrb[m]  = '1;
                s_wready    = 1'b1;
                s_wlast     = (i == beats - 1);
                #1;
                check("s_wvalid", s_wvalid, 1'b1);
                check("s_wdata", s_wdata, pat);
                check("wready_own", m_wready[m], 1'b1);
                check("wlast_own", m_wlast[m], (i == beats - 1));
                check("wready_other", m_wready[o], 1'b0);
                step();
            end
            m_wvalid[m] = 1'b0;
            s_wready    = 1'b0;
            s_wlast     = 1'b0;
            m_bready[m] = 1'b1;
            s_bid       = m_awid[m];
            s_bresp     = (m == 1) ? 2'b10 : 2'b01;
            for (int i = 0; i < bdelay; i++) begin
                #1;
                check("bvalid_wait", m_bvalid[m], 1'b0);
                check("grant_wresp", grant, g);
                step();
            end
            s_bvalid = 1'b1;
            #1;
            check("bvalid_own", m_bvalid[m], 1'b1);
            check("bid_own", m_bid[m], m_awid[m]);
            check("bresp_own", m_bresp[m], (m == 1) ? 2'b10 : 2'b01);
            check("s_bready", s_bready, 1'b1);
            check("bvalid_other", m_bvalid[o], 1'b0);
            step();
            s_bvalid    = 1'b0;
            m_bready[m] = 1'b0;
        end else begin
            check("s_arvalid", s_arvalid, 1'b1);
            check("s_araddr", s_araddr, m_araddr[m]);
            check("s_arid", s_arid, m_arid[m]);
            check("s_arlen", s_arlen, m_arlen[m]);
            s_arready = 1'b1;
            #1;
            check("arready_own", m_arready[m], 1'b1);
            check("arready_other", m_arready[o], 1'b0);
            step();
            s_arready = 1'b0;
            if (drop) m_arvalid[m] = 1'b0;
            m_rready[m] = 1'b1;
            for (int i = 0; i < beats; i++) begin
                if (i == stall_at) begin
                    for (int k = 0; k < stall_len; k++) begin
                        s_rvalid = 1'b0;
                        s_rlast  = 1'b0;
                        #1;
                        check("rvalid_stall", m_rvalid[m], 1'b0);
                        check("grant_stall", grant, g);
                        check("awready_other_stall", m_awready[o], 1'b0);
                        step();
                    end
                end
                pat = 128'((m + 1) * 4096 + i);
                s_rvalid = 1'b1;
                s_rdata  = pat;
                s_rid    = m_arid[m];
                s_rresp  = 2'b00;
                s_rlast  = (i == beats - 1);
                #1;
                check("rvalid_own", m_rvalid[m], 1'b1);
                check("rdata_own", m_rdata[m], pat);
                check("rid_own", m_rid[m], m_arid[m]);
                check("rlast_own", m_rlast[m], (i == beats - 1));
                check("s_rready", s_rready, 1'b1);
                check("rvalid_other", m_rvalid[o], 1'b0);
                step();
            end
            s_rvalid    = 1'b0;
            s_rlast     = 1'b0;
            m_rready[m] = 1'b0;
        end
        check("grant_idle", grant, 2'b00);
        check("s_awvalid_idle", s_awvalid, 1'b0);
        check("s_arvalid_idle", s_arvalid, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_awaddr[i] = 32'h1000_0000 * (i + 1) + 32'h100;
            m_araddr[i] = 32'h2000_0000 * (i + 1) + 32'h40;
            m_awid[i]   = 4'(5 + i * 5);
            m_arid[i]   = 4'(3 + i * 6);
            m_awlen[i]  = 6'd0;
            m_arlen[i]  = 6'd0;
            m_wdata[i]  = '0;
            m_wstrb[i]  = '0;
        end
        m_awvalid = '0; m_arvalid = '0; m_wvalid = '0; m_bready = '0; m_rready = '0;
        s_awready = 0; s_wready = 0; s_wlast = 0; s_bid = '0; s_bresp = '0; s_bvalid = 0;
        s_arready = 0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rvalid = 0; s_rlast = 0;

        // Reset with both masters already requesting reads (tie).
        m_arvalid = 2'b11;
        repeat (3) step();
        check("rst_grant", grant, 2'b00);
        check("rst_s_arvalid", s_arvalid, 1'b0);
        check("rst_arready", {m_arready, m_awready}, 4'b0);
        aresetn = 1'b1;
        #1;
        check("post_rst_grant", grant, 2'b00);
        check("post_rst_s_arvalid", s_arvalid, 1'b0);
        check("post_rst_s_rready", s_rready, 1'b0);

        // Tie: m0 first, m1 one IDLE cycle after m0's rlast.
        txn(0, 1'b0, 1, 0, 1'b0, -1, 0);
        txn(1, 1'b0, 1, 0, 1'b1, -1, 0);
        m_arvalid = 2'b00;

        // Single write m0: awlen=3, 4 beats, bvalid 2 cycles later.
        m_awlen[0] = 6'd3;
        m_awvalid[0] = 1'b1;
        txn(0, 1'b1, 4, 2, 1'b1, -1, 0);

        // Write priority inside m1.
        m_awlen[1] = 6'd1;
        m_arlen[1] = 6'd1;
        m_awvalid[1] = 1'b1;
        m_arvalid[1] = 1'b1;
        txn(1, 1'b1, 2, 1, 1'b1, -1, 0);
        txn(1, 1'b0, 2, 0, 1'b1, -1, 0);

        // Round-robin: both keep requesting writes.
        m_awlen[0] = 6'd0;
        m_awlen[1] = 6'd0;
        m_awvalid = 2'b11;
        for (int t = 0; t < 6; t++) txn(t % 2, 1'b1, 1, 0, 1'b0, -1, 0);
        m_awvalid = 2'b00;

        // Stall: m0 4-beat read, slave idle 50 cycles before beat 3, m1 waiting.
        m_arlen[0] = 6'd3;
        m_arvalid[0] = 1'b1;
        m_awvalid[1] = 1'b1;
        txn(0, 1'b0, 4, 0, 1'b1, 2, 50);
        txn(1, 1'b1, 1, 0, 1'b1, -1, 0);

        // Reset after beat 2 of an 8-beat m1 write.
        m_awlen[1] = 6'd7;
        m_awvalid[1] = 1'b1;
        step();
        check("mid_grant", grant, 2'b10);
        s_awready = 1'b1;
        step();
        s_awready = 1'b0;
        m_awvalid[1] = 1'b0;
        m_wvalid[1] = 1'b1;
        s_wready = 1'b1;
        repeat (2) step();
        aresetn = 1'b0;
        step();
        check("mid_rst_grant", grant, 2'b00);
        check("mid_rst_wready", m_wready, 2'b00);
        check("mid_rst_s_wvalid", s_wvalid, 1'b0);
        aresetn = 1'b1;
        #1;
        check("mid_post_wready", m_wready, 2'b00);
        check("mid_post_awready", m_awready, 2'b00);
        m_wvalid[1] = 1'b0;
        s_wready = 1'b0;
        m_awlen[1] = 6'd1;
        m_awvalid[1] = 1'b1;
        txn(1, 1'b1, 2, 1, 1'b1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_ddr3_arbiter.md
AXI_DDR3_ARBITER -- requirements
Module: axi_ddr3_arbiter

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: address width on all AR/AW channels.
REQ-002 SHALL have parameter AXI_ID_WIDTH, default 4: ID width on all ID fields.
REQ-003 SHALL have parameter AXI_BURST_WIDTH, default 6: width of awlen/arlen.
REQ-004 SHALL have parameter AXI_DATA_WIDTH, default 128: data width; strobe width is AXI_DATA_WIDTH/8.
REQ-005 SHALL have port aclk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port aresetn, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have, for each of m0_ and m1_, write-address inputs awaddr, awid, awlen, awvalid and output awready.
REQ-008 SHALL have, for each of m0_ and m1_, inputs wdata, wstrb, wvalid and outputs wready, wlast (last beat accepted).
REQ-009 SHALL have, for each of m0_ and m1_, outputs bid, bresp, bvalid and input bready.
REQ-010 SHALL have, for each of m0_ and m1_, read-address inputs araddr, arid, arlen, arvalid and output arready.
REQ-011 SHALL have, for each of m0_ and m1_, outputs rid, rdata, rresp, rvalid, rlast and input rready.
REQ-012 SHALL have an s_ port set that is the mirror of one master set: master-side inputs become outputs, and s_wlast/s_rlast are inputs.
REQ-013 SHALL have port grant, output, 2 bits: one-hot current owner (00 when idle), for debug.

Function
REQ-014 SHALL serialise access so that exactly one transaction is outstanding on the s_ port at any time.
REQ-015 SHALL implement states IDLE, ADDR, WDATA, WRESP, RDATA.
REQ-016 Requests: mX requests when mX_awvalid or mX_arvalid is high.
REQ-017 IDLE SHALL pick an owner when any master requests, register the grant, and move to ADDR on the next clock.
REQ-018 Arbitration SHALL be round-robin with a 1-bit last-owner pointer.
- With both masters requesting, the master that was not last served wins.
- With one master requesting, that master wins regardless of the pointer.
REQ-019 Within the owner, a write SHALL take priority over a read when awvalid and arvalid are both high; the kind is latched at grant.
REQ-020 ADDR SHALL drive the owner's AW or AR fields to the s_ port and route s_awready/s_arready back only to the owner.
REQ-021 ADDR SHALL leave on the address handshake: to WDATA for a write, to RDATA for a read.
REQ-022 WDATA SHALL route the owner's w channel to s_, and route s_wready and s_wlast back to the owner; it moves to WRESP on s_wlast.
REQ-023 WRESP SHALL route s_b* to the owner and move to IDLE on s_bvalid & owner bready.
REQ-024 RDATA SHALL route s_r* to the owner and move to IDLE on s_rlast.
REQ-025 On each return to IDLE the pointer SHALL update to the completed owner.
REQ-026 No new grant SHALL be made on the cycle the arbiter returns to IDLE, so the minimum gap between transactions is 1 cycle.
REQ-027 The non-owner SHALL see all ready, valid and last outputs at 0; its data outputs are don't-care and are held at 0.
REQ-028 IDs, lengths, data and responses SHALL pass through unmodified; the arbiter adds no ID bits.
REQ-029 Every path from an s_ input to an m_ output, and from an m_ input to an s_ output, SHALL be combinational through the grant mux, adding no data latency.
REQ-030 In IDLE all s_ valid outputs SHALL be 0 and s_bready/s_rready SHALL be 0.
REQ-031 The arbiter SHALL hold its state indefinitely when the slave stalls: no timeout.
REQ-032 A requester that drops valid before its address handshake SHALL keep the grant; this is AXI-illegal and is not recovered.

Reset
REQ-033 On aresetn low at a clock edge, state SHALL go to IDLE, grant to 00 and the pointer to m1, so that m0 wins the first tie.
REQ-034 During reset and on the first cycle after it, every m_ and s_ valid, ready and last output SHALL be 0.
REQ-035 A reset mid-burst SHALL abandon the transaction with no completion response; the slave is reset by the same aresetn.

Verification
REQ-036 Single write: m0 writes with awlen=3 and 4 beats, slave bvalid 2 cycles later -> m0 sees 4 wready beats, wlast on beat 4, then bvalid; m1 sees no activity; grant returns to 00.
REQ-037 Tie: m0 and m1 both assert arvalid (arlen=0) from reset -> m0 is served first; m1 is granted 1 cycle after m0's rlast.
REQ-038 Round-robin: both masters issue writes back-to-back for 6 transactions -> grants alternate m0, m1, m0, m1, m0, m1.
REQ-039 Write priority: m1 asserts awvalid and arvalid together -> the write completes (bvalid) before m1_arready rises.
REQ-040 Stall: slave holds s_rvalid low for 50 cycles mid-burst -> grant is unchanged, m1 requests are not granted, and the burst then completes.
REQ-041 Reset mid-WDATA: aresetn low for 1 cycle after beat 2 of 8 -> state is IDLE and all readies are 0; a fresh m1 write then completes normally.
